// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler: FSM state encoding,
// default widths and the round-robin winner search.
package uart_tx_sched_pkg;

    localparam int unsigned DefDataLength   = 8;
    localparam int unsigned DefNumReq       = 4;
    localparam int unsigned DefTimeoutTicks = 16;
    localparam int unsigned MaxReq          = 8;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} sched_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit at or after ptr, wrapping modulo num (num <= MaxReq).
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int unsigned num);
        rr_pick_t    res;
        int unsigned cand;
        logic [2:0]  cand_idx;
        res = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            cand     = (32'(ptr) + i) % num;
            cand_idx = cand[2:0];
            if (i < num && !res.found && valid[cand_idx]) begin
                res.found = 1'b1;
                res.idx   = cand_idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_edge_det.sv
// Registered single-bit rising-edge detector; rise is high in the first cycle sig is seen high.
module uart_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_SCHED_TIMEOUT_EN to build the WAIT_DONE baud-tick timeout and timeout_err.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned DATA_LENGTH   = DefDataLength,
    parameter int unsigned NUM_REQ       = DefNumReq,
    parameter int unsigned TIMEOUT_TICKS = DefTimeoutTicks
) (
    input  logic                           tx_clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           baudratetx,
    input  logic                           tx_done,
    output logic                           send,
    output logic [DATA_LENGTH-1:0]         parallel_datain,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    sched_state_t           state_q, state_d;
    logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]         grant_q, grant_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic                   send_q, send_d;
    logic                   baud_pend_q, baud_pend_d;
    logic                   baud_rise, done_rise;
    logic                   tmo_hit;
    rr_pick_t               pick;
    logic [MaxReq-1:0]      valid_ext;
    logic [2:0]             ptr_ext;
    logic [IdW-1:0]         win_idx;

    uart_edge_det u_baud_edge (
        .clk  (tx_clk),
        .rst  (rst),
        .sig  (baudratetx),
        .rise (baud_rise)
    );

    uart_edge_det u_done_edge (
        .clk  (tx_clk),
        .rst  (rst),
        .sig  (tx_done),
        .rise (done_rise)
    );

    assign valid_ext = MaxReq'(req_valid);
    assign ptr_ext   = 3'(rr_ptr_q);
    assign pick      = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    assign win_idx   = pick.idx[IdW-1:0];

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_TICKS + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_err_q, tmo_err_d;

    assign tmo_hit = baud_rise && (tmo_cnt_q == CntW'(TIMEOUT_TICKS - 1));

    // Held at zero outside WAIT_DONE so every wait starts from a cleared count.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_err_d = tmo_err_q;
        if (state_q == WAIT_DONE) begin
            tmo_cnt_d = baud_rise ? tmo_cnt_q + 1'b1 : tmo_cnt_q;
            if (!done_rise && tmo_hit) begin
                tmo_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        data_d      = data_q;
        ready_d     = '0;
        send_d      = 1'b0;
        baud_pend_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick.found) begin
                    ready_d[win_idx] = 1'b1;
                    data_d           = req_data[32'(win_idx) * DATA_LENGTH +: DATA_LENGTH];
                    grant_d          = win_idx;
                    rr_ptr_d         = (win_idx == IdW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d          = LOAD;
                end
            end
            LOAD: state_d = SEND;
            SEND: begin
                // A baud edge in the first SEND cycle is remembered so send is still seen high.
                if (send_q && (baud_rise || baud_pend_q)) begin
                    state_d = WAIT_DONE;
                end else begin
                    send_d      = 1'b1;
                    baud_pend_d = baud_pend_q | baud_rise;
                end
            end
            WAIT_DONE: begin
                if (done_rise || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            data_q      <= '0;
            ready_q     <= '0;
            send_q      <= 1'b0;
            baud_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            send_q      <= send_d;
            baud_pend_q <= baud_pend_d;
        end
    end

    assign req_ready       = ready_q;
    assign parallel_datain = data_q;
    assign grant_id        = grant_q;
    assign send            = send_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (4 requesters, 8-bit data, 4-tick timeout).
module tb_uart_tx_scheduler;

    logic        tx_clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        baudratetx = 1'b0;
    logic        tx_done = 1'b0;
    logic        send;
    logic [7:0]  parallel_datain;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned pulse_cnt [4] = '{0, 0, 0, 0};

    uart_tx_scheduler #(
        .DATA_LENGTH   (8),
        .NUM_REQ       (4),
        .TIMEOUT_TICKS (4)
    ) dut (
        .tx_clk          (tx_clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .baudratetx      (baudratetx),
        .tx_done         (tx_done),
        .send            (send),
        .parallel_datain (parallel_datain),
        .grant_id        (grant_id),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 tx_clk = ~tx_clk;

    always @(negedge tx_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i] === 1'b1) pulse_cnt[i] <= pulse_cnt[i] + 1;
        end
    end

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid  = '0;
        baudratetx = 1'b0;
        tx_done    = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a grant, then runs that frame to completion, ending in IDLE.
    task automatic serve(output logic [1:0] gid, output logic [7:0] pd,
                         output logic [3:0] rdy, output int waited);
        waited = 0;
        rdy    = '0;
        while (rdy == 4'b0000 && waited < 8) begin
            step();
            waited++;
            rdy = req_ready;
        end
        gid = grant_id;
        pd  = parallel_datain;
        if (rdy != 4'b0000) begin
            req_valid  = req_valid & ~rdy;
            step();
            step();
            baudratetx = 1'b1;
            step();
            baudratetx = 1'b0;
            tx_done    = 1'b1;
            step();
            tx_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_data   = 32'hDEADBEEF;
        baudratetx = 1'b1;
        tx_done    = 1'b1;
        step();
        step();
        total++;
        if ({busy, send, req_ready, grant_id, parallel_datain, timeout_err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b send=%b rdy=%b gid=%0d pd=%h err=%b want all 0",
                     busy, send, req_ready, grant_id, parallel_datain, timeout_err);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_data  = 32'h0000_0001;
        req_valid = 4'b0001;
        step();
        total++;
        if (req_ready !== 4'b0001 || parallel_datain !== 8'h01 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL single_grant got rdy=%b pd=%h gid=%0d want rdy=0001 pd=01 gid=0",
                     req_ready, parallel_datain, grant_id);
        end
        total++;
        if (busy !== 1'b1 || send !== 1'b0) begin
            bad++;
            $display("FAIL single_load got busy=%b send=%b want busy=1 send=0", busy, send);
        end
        req_valid = 4'b0000;
        step();
        total++;
        if (req_ready !== 4'b0000 || send !== 1'b0) begin
            bad++;
            $display("FAIL single_ready_pulse got rdy=%b send=%b want 0000 0", req_ready, send);
        end
        step();
        total++;
        if (send !== 1'b1) begin
            bad++;
            $display("FAIL single_send_rise got send=%b want 1", send);
        end
        step();
        total++;
        if (send !== 1'b1 || parallel_datain !== 8'h01) begin
            bad++;
            $display("FAIL single_send_hold got send=%b pd=%h want 1 01", send, parallel_datain);
        end
        baudratetx = 1'b1;
        step();
        baudratetx = 1'b0;
        total++;
        if (send !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_send_fall got send=%b busy=%b want 0 1", send, busy);
        end
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_wait_done got busy=%b want 1", busy);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        total++;
        if (busy !== 1'b0 || parallel_datain !== 8'h01) begin
            bad++;
            $display("FAIL single_done got busy=%b pd=%h want 0 01", busy, parallel_datain);
        end
    endtask

    task automatic test_all_four();
        logic [7:0]  exp_data [4] = '{8'h03, 8'h07, 8'h0F, 8'h1F};
        logic [3:0]  exp_rdy;
        logic [1:0]  gid;
        logic [7:0]  pd;
        logic [3:0]  rdy;
        int          waited;
        int unsigned base [4];
        do_reset();
        for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
        req_data  = {8'h1F, 8'h0F, 8'h07, 8'h03};
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = 4'b0001 << k;
            serve(gid, pd, rdy, waited);
            total++;
            if (rdy !== exp_rdy || gid !== 2'(k) || pd !== exp_data[k] || waited != 1) begin
                bad++;
                $display("FAIL all_four_frame%0d got rdy=%b gid=%0d pd=%h wait=%0d want %b %0d %h 1",
                         k, rdy, gid, pd, waited, exp_rdy, k, exp_data[k]);
            end
        end
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pulse_cnt[i] - base[i] != 1) begin
                bad++;
                $display("FAIL all_four_pulses req%0d got %0d want 1", i, pulse_cnt[i] - base[i]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] masks [8] = '{4'b1101, 4'b1101, 4'b1101, 4'b0101,
                                  4'b0100, 4'b1101, 4'b1100, 4'b1101};
        logic [1:0] exp_gid [8] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [1:0] gid;
        logic [7:0] pd;
        logic [3:0] rdy;
        int         waited;
        int         since = 0;
        int         max_wait = 0;
        do_reset();
        req_data = 32'hA3A2A1A0;
        for (int f = 0; f < 8; f++) begin
            req_valid = masks[f];
            serve(gid, pd, rdy, waited);
            total++;
            if (gid !== exp_gid[f] || rdy !== (4'b0001 << exp_gid[f]) || pd !== {6'h28, exp_gid[f]}) begin
                bad++;
                $display("FAIL fair_frame%0d got gid=%0d rdy=%b pd=%h want gid=%0d",
                         f, gid, rdy, pd, exp_gid[f]);
            end
            if (gid == 2'd2) since = 0;
            else since++;
            if (since > max_wait) max_wait = since;
        end
        req_valid = '0;
        total++;
        if (max_wait > 3) begin
            bad++;
            $display("FAIL fair_max_wait got %0d want <=3", max_wait);
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b0010;
        step();
        total++;
        if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL rst_mid_grant got rdy=%b gid=%0d want 0010 1", req_ready, grant_id);
        end
        req_valid = '0;
        step();
        step();
        total++;
        if (send !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre got send=%b want 1", send);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (send !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_after got send=%b busy=%b gid=%0d rdy=%b want 0 0 0 0000",
                     send, busy, grant_id, req_ready);
        end
        req_valid = 4'hF;
        step();
        total++;
        if (req_ready !== 4'b0001 || grant_id !== 2'd0 || parallel_datain !== 8'h11) begin
            bad++;
            $display("FAIL rst_mid_ptr got rdy=%b gid=%0d pd=%h want 0001 0 11",
                     req_ready, grant_id, parallel_datain);
        end
        do_reset();
    endtask

    task automatic test_stray_done();
        do_reset();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        total++;
        if (busy !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL stray_idle got busy=%b rdy=%b want 0 0000", busy, req_ready);
        end
        step();
        total++;
        if (busy !== 1'b0 || req_ready !== 4'b0000 || send !== 1'b0) begin
            bad++;
            $display("FAIL stray_idle2 got busy=%b rdy=%b send=%b want 0 0000 0",
                     busy, req_ready, send);
        end
        // tx_done edges in SEND must not move the FSM, even alongside a baud edge.
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        total++;
        if (send !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_in_send got send=%b busy=%b want 1 1", send, busy);
        end
        baudratetx = 1'b1;
        tx_done    = 1'b1;
        step();
        baudratetx = 1'b0;
        tx_done    = 1'b0;
        total++;
        if (send !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL baud_and_done got send=%b busy=%b want 0 1", send, busy);
        end
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL done_ignored_wait got busy=%b want 1", busy);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL done_after_wait got busy=%b want 0", busy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_data  = 32'h77665544;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step();
        baudratetx = 1'b1;
        step();
        baudratetx = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            baudratetx = 1'b1;
            step();
            baudratetx = 1'b0;
            step();
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fire got err=%b busy=%b want 1 0", timeout_err, busy);
        end
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        total++;
        if (req_ready !== 4'b0100 || parallel_datain !== 8'h66) begin
            bad++;
            $display("FAIL timeout_next got rdy=%b pd=%h want 0100 66", req_ready, parallel_datain);
        end
        step();
        step();
        baudratetx = 1'b1;
        step();
        baudratetx = 1'b0;
        tx_done    = 1'b1;
        step();
        tx_done = 1'b0;
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_sticky got err=%b busy=%b want 1 0", timeout_err, busy);
        end
        do_reset();
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear got err=%b want 0", timeout_err);
        end
`else
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL no_timeout_wait got err=%b busy=%b want 0 1", timeout_err, busy);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout_done got err=%b busy=%b want 0 0", timeout_err, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_reset_mid_send();
        test_stray_done();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. It sits between the producers and the UART top-level transmit inputs. It accepts one byte per grant over a valid/ready handshake and drives the transmitter's `send`/`parallel_datain` pair. It then holds off the next grant until the transmitter reports completion on `tx_done`.

## Interface
Parameters:
- `DATA_LENGTH`, 8: bits per character; must match the transmitter.
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_TICKS`, 16: baud ticks allowed between `send` acceptance and `tx_done` (used only with the timeout feature).

Ports:
- `tx_clk`, in, 1: single clock. All logic runs on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, `NUM_REQ`: per-requester byte pending.
- `req_data`, in, `NUM_REQ*DATA_LENGTH`: packed bytes; requester i occupies slice `[i*DATA_LENGTH +: DATA_LENGTH]`.
- `req_ready`, out, `NUM_REQ`: one-hot, one-cycle pulse when that requester's byte is taken.
- `baudratetx`, in, 1: transmitter baud tick, level synchronous to `tx_clk`; its rising edge is detected internally.
- `tx_done`, in, 1: transmitter completion; its rising edge is detected internally.
- `send`, out, 1: transmit strobe to the UART.
- `parallel_datain`, out, `DATA_LENGTH`: byte to the UART, held stable from LOAD until the next grant.
- `grant_id`, out, `clog2(NUM_REQ)`: index of the requester currently owning the transmitter.
- `busy`, out, 1: high in every state except IDLE.
- `timeout_err`, out, 1: sticky timeout flag (timeout build only; otherwise tied 0).

## Operation
- The state machine has four states: IDLE, LOAD, SEND, WAIT_DONE.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Pulse that requester's `req_ready` and latch its byte into `parallel_datain`.
  - Set `grant_id` to the winner and `rr_ptr` to winner+1 (mod `NUM_REQ`), then go to LOAD.
- **LOAD**: one cycle with the data stable, then go to SEND.
- **SEND**
  - `send` is high.
  - On the first `baudratetx` rising edge seen in SEND, deassert `send` on the next cycle and go to WAIT_DONE.
- **WAIT_DONE**: on a `tx_done` rising edge, go to IDLE.
- `tx_done` edges outside WAIT_DONE are ignored.
- A requester that drops `req_valid` before being granted is skipped. No byte is taken without a `req_ready` pulse.
- Arbitration is fair: a continuously requesting requester waits at most `NUM_REQ-1` frames.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `send` 0, `parallel_datain` 0, `req_ready` 0, `grant_id` 0, `busy` 0, `timeout_err` 0.
  - Both edge-detect registers are cleared.
- Grant latency: `req_ready` is asserted in the cycle after `req_valid` is sampled high in IDLE; `send` rises 2 cycles after `req_ready`.
- `send` stays high until the cycle after the first `baudratetx` rising edge observed while in SEND. Minimum width is 1 cycle; maximum is one baud period + 1 cycle.
- If a `baudratetx` edge and a `tx_done` edge occur in the same cycle in SEND, only the baud edge acts; `tx_done` is ignored.
- Next grant: at the earliest, the cycle after the `tx_done` rising edge (IDLE → grant evaluated immediately in that IDLE cycle).
- `rst` asserted mid-frame: everything returns to reset values on the next edge. The in-flight byte is abandoned, and no `req_ready` is reissued for it.
- Simultaneous `req_valid` from all requesters with `rr_ptr`=0 gives the grant order 0,1,2,3,0,...

## Configuration
- Macro: `UART_TX_SCHED_TIMEOUT_EN`.
- **Defined**:
  - In WAIT_DONE, count `baudratetx` rising edges (counter width `clog2(TIMEOUT_TICKS+1)`, cleared on entering WAIT_DONE).
  - When the count reaches `TIMEOUT_TICKS` without `tx_done`, set `timeout_err` (sticky until `rst`) and return to IDLE. The byte counts as sent; `rr_ptr` is not rewound.
- **Undefined**: no counter is built, `timeout_err` is constant 0, and WAIT_DONE waits indefinitely.

## Structure
- Package `uart_tx_sched_pkg`:
  - state enum `sched_state_t` {IDLE, LOAD, SEND, WAIT_DONE};
  - function `rr_pick(valid, ptr)` returning winner index and found flag;
  - default-width constants.
- Sub-module `uart_edge_det`: single-bit registered rising-edge detector, instantiated twice (`baudratetx`, `tx_done`).
- Top: state register, `rr_ptr`, data/ID latches, and the optional timeout counter.

## Test plan
- **Single request**: `req_valid`=4'b0001, data 8'h01 → `req_ready[0]` pulses once, `parallel_datain`=8'h01, `send` high until the cycle after the next baud edge, `busy` falls after `tx_done`.
- **All four request**, data 8'h03/07/0F/1F → transmitted order 03,07,0F,1F; `grant_id` 0,1,2,3; exactly one `req_ready` pulse each.
- **Fairness**: requester 2 held valid continuously while 0 and 3 toggle → 2 never waits more than 3 frames; pointer wraps 3→0.
- **Reset mid-SEND**: `rst` for 1 cycle while `send`=1 → `send`=0, `busy`=0 and `grant_id`=0 the next cycle; the next request starts from `rr_ptr` 0.
- **Timeout (macro defined, `TIMEOUT_TICKS`=4)**: `tx_done` held low → after 4 baud edges in WAIT_DONE, `timeout_err`=1 and the state returns to IDLE; the next request is still served, and `timeout_err` stays 1 until `rst`.
- **Stray `tx_done`** pulse while in IDLE → no state change and no `req_ready`.
